// File: rtl/mips_trace_checker.sv
// Trace checker for the single-cycle MIPS core: compares retired (PC, ALU result) pairs against a loaded table.
// Optional feature macro: TRACE_CHECK_STOP_ON_ERR_EN (end the run on the first mismatch).
module mips_trace_checker #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [XLEN-1:0]            load_pc,
  input  logic [XLEN-1:0]            load_res,
  input  logic [$clog2(DEPTH):0]     num_entries,
  input  logic                       start,
  input  logic                       valid_in,
  input  logic [XLEN-1:0]            pc_in,
  input  logic [XLEN-1:0]            result_in,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timed_out,
  output logic [$clog2(DEPTH)-1:0]   err_index,
  output logic [$clog2(DEPTH):0]     mismatch_count,
  output logic [$clog2(TIMEOUT):0]   cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_n;
  logic [AW-1:0]   idx_q;
  logic [AW-1:0]   last_idx_q;
  logic [AW-1:0]   last_idx_n;
  logic [NW-1:0]   n_clamp;
  logic [NW-1:0]   n_clamp_m1;
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] res_mem [DEPTH];

  logic hit, start_run, consume, miss, last, stop_en;
  logic any_miss_n, tmo_n;

  function automatic logic [NW-1:0] clamp_entries(input logic [NW-1:0] n);
    return (n > NW'(DEPTH)) ? NW'(DEPTH) : n;
  endfunction

  function automatic logic [CW-1:0] sat_cycle(input logic [CW-1:0] c);
    return (c == CW'(TIMEOUT)) ? c : c + CW'(1);
  endfunction

  function automatic logic [NW-1:0] sat_miss(input logic [NW-1:0] m);
    return (m == NW'(DEPTH)) ? m : m + NW'(1);
  endfunction

`ifdef TRACE_CHECK_STOP_ON_ERR_EN
  assign stop_en = 1'b1;
`else
  assign stop_en = 1'b0;
`endif

  assign hit        = (pc_mem[idx_q] == pc_in) && (res_mem[idx_q] == result_in);
  assign n_clamp    = clamp_entries(num_entries);
  assign n_clamp_m1 = n_clamp - NW'(1);
  assign last_idx_n = n_clamp_m1[AW-1:0];

  // Table is data only: never reset, and frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (load_en && state_q != RUN) begin
      pc_mem[load_addr]  <= load_pc;
      res_mem[load_addr] <= load_res;
    end
  end

  always_comb begin
    state_n    = state_q;
    start_run  = 1'b0;
    consume    = 1'b0;
    miss       = 1'b0;
    last       = 1'b0;
    any_miss_n = (mismatch_count != '0);
    tmo_n      = timed_out;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_run  = 1'b1;
          any_miss_n = 1'b0;
          tmo_n      = 1'b0;
          state_n    = (num_entries == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        consume = valid_in;
        miss    = valid_in && !hit;
        last    = valid_in && (idx_q == last_idx_q);
        if (miss) any_miss_n = 1'b1;
        // Completing the last entry takes priority over a coincident timeout.
        if (last || (stop_en && miss)) begin
          state_n = DONE;
        end else if (cycle_count == CW'(TIMEOUT - 1)) begin
          state_n = DONE;
          tmo_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      last_idx_q     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      timed_out      <= 1'b0;
      err_index      <= '0;
      mismatch_count <= '0;
      cycle_count    <= '0;
    end else begin
      state_q   <= state_n;
      busy      <= (state_n == RUN);
      done      <= (state_n == DONE);
      pass      <= (state_n == DONE) && !any_miss_n && !tmo_n;
      fail      <= (state_n == DONE) && (any_miss_n || tmo_n);
      timed_out <= tmo_n;
      if (start_run) begin
        idx_q          <= '0;
        last_idx_q     <= last_idx_n;
        err_index      <= '0;
        mismatch_count <= '0;
        cycle_count    <= '0;
      end else if (state_q == RUN) begin
        cycle_count <= sat_cycle(cycle_count);
        if (consume) idx_q <= idx_q + AW'(1);
        if (miss) begin
          mismatch_count <= sat_miss(mismatch_count);
          if (mismatch_count == '0) err_index <= idx_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_trace_checker.sv
// Directed bench for mips_trace_checker (DEPTH=8, TIMEOUT=8) with hand-computed expectations.
module tb_mips_trace_checker;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic [2:0]        load_addr;
  logic [XLEN-1:0]   load_pc;
  logic [XLEN-1:0]   load_res;
  logic [3:0]        num_entries;
  logic              start;
  logic              valid_in;
  logic [XLEN-1:0]   pc_in;
  logic [XLEN-1:0]   result_in;
  logic              busy, done, pass, fail, timed_out;
  logic [2:0]        err_index;
  logic [3:0]        mismatch_count;
  logic [3:0]        cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_pc  [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C};
  logic [31:0] exp_res [8] = '{32'd5, 32'd10, 32'd15, 32'd4, 32'd20, 32'd21, 32'd22, 32'd23};

  mips_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_pc(load_pc), .load_res(load_res), .num_entries(num_entries),
    .start(start), .valid_in(valid_in), .pc_in(pc_in), .result_in(result_in),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timed_out(timed_out),
    .err_index(err_index), .mismatch_count(mismatch_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int a, input logic [31:0] p, input logic [31:0] r);
    load_en = 1'b1; load_addr = 3'(a); load_pc = p; load_res = r;
    tick();
    load_en = 1'b0;
  endtask

  task automatic start_run(input int n);
    num_entries = 4'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] p, input logic [31:0] r);
    valid_in = 1'b1; pc_in = p; result_in = r;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic chk_end(input string tag, input logic ep, input logic ef, input logic et,
                         input int emm, input int ecyc);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'(ep));
    chk({tag, "_fail"}, 32'(fail), 32'(ef));
    chk({tag, "_tmo"},  32'(timed_out), 32'(et));
    chk({tag, "_mm"},   32'(mismatch_count), 32'(emm));
    chk({tag, "_cyc"},  32'(cycle_count), 32'(ecyc));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_tmo"},  32'(timed_out), 32'd0);
    chk({tag, "_eidx"}, 32'(err_index), 32'd0);
    chk({tag, "_mm"},   32'(mismatch_count), 32'd0);
    chk({tag, "_cyc"},  32'(cycle_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_pc = '0; load_res = '0;
    num_entries = '0; start = 1'b0; valid_in = 1'b0; pc_in = '0; result_in = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: clean 4-entry run
    for (int i = 0; i < 4; i++) load_entry(i, exp_pc[i], exp_res[i]);
    start_run(4);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cyc0", 32'(cycle_count), 32'd0);
    feed(exp_pc[0], exp_res[0]);
    feed(exp_pc[1], exp_res[1]);
    chk("t1_cyc2", 32'(cycle_count), 32'd2);
    feed(exp_pc[2], exp_res[2]);
    feed(exp_pc[3], exp_res[3]);
    chk_end("t1", 1'b1, 1'b0, 1'b0, 0, 4);

    // 2: entry 2 fed a wrong result
    start_run(4);
    feed(exp_pc[0], exp_res[0]);
    feed(exp_pc[1], exp_res[1]);
    feed(exp_pc[2], 32'd14);
`ifdef TRACE_CHECK_STOP_ON_ERR_EN
    chk_end("t2", 1'b0, 1'b1, 1'b0, 1, 3);
`else
    chk("t2_busy_mid", 32'(busy), 32'd1);
    chk("t2_mm_mid", 32'(mismatch_count), 32'd1);
    feed(exp_pc[3], exp_res[3]);
    chk_end("t2", 1'b0, 1'b1, 1'b0, 1, 4);
`endif
    chk("t2_eidx", 32'(err_index), 32'd2);

    // 3: only two entries arrive, timeout after TIMEOUT cycles
    start_run(4);
    feed(exp_pc[0], exp_res[0]);
    feed(exp_pc[1], exp_res[1]);
    for (int i = 0; i < 20 && !done; i++) tick();
    chk_end("t3", 1'b0, 1'b1, 1'b1, 0, 8);

    // 4a: zero entries finishes immediately
    start_run(0);
    chk_end("t4a", 1'b1, 1'b0, 1'b0, 0, 0);

    // 4b: DEPTH+1 requested clamps to DEPTH; last compare coincides with timeout edge
    for (int i = 4; i < 8; i++) load_entry(i, exp_pc[i], exp_res[i]);
    start_run(DEPTH + 1);
    for (int i = 0; i < 7; i++) feed(exp_pc[i], exp_res[i]);
    chk("t4b_busy7", 32'(busy), 32'd1);
    feed(exp_pc[7], exp_res[7]);
    chk_end("t4b", 1'b1, 1'b0, 1'b0, 0, 8);
    feed(32'hDEAD, 32'hBEEF);
    chk("t4b_mm_after", 32'(mismatch_count), 32'd0);
    chk("t4b_pass_after", 32'(pass), 32'd1);

    // 5: asynchronous reset mid-run, then restart with the retained table
    start_run(4);
    feed(exp_pc[0], exp_res[0]);
    feed(exp_pc[1], exp_res[1]);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    rst = 1'b0;
    tick();
    start_run(4);
    for (int i = 0; i < 4; i++) feed(exp_pc[i], exp_res[i]);
    chk_end("t5", 1'b1, 1'b0, 1'b0, 0, 4);

    // 6: load with start writes; load and start during RUN are ignored
    load_en = 1'b1; load_addr = 3'd3; load_pc = 32'hC; load_res = 32'd99;
    num_entries = 4'd4; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    chk("t6_busy", 32'(busy), 32'd1);
    feed(exp_pc[0], exp_res[0]);
    feed(exp_pc[1], exp_res[1]);
    load_en = 1'b1; load_addr = 3'd3; load_pc = 32'hC; load_res = 32'd4;
    start = 1'b1;
    feed(exp_pc[2], exp_res[2]);
    load_en = 1'b0; start = 1'b0;
    chk("t6_cyc3", 32'(cycle_count), 32'd3);
    chk("t6_mm_mid", 32'(mismatch_count), 32'd0);
    feed(32'hC, 32'd99);
    chk_end("t6", 1'b1, 1'b0, 1'b0, 0, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
